serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new addition; sampled on rising clk.
REQ-005 SHALL have port a  input  WIDTH  operand A, sampled with start.
REQ-006 SHALL have port b  input  WIDTH  operand B, sampled with start.
REQ-007 SHALL have port cin  input  1  carry-in, sampled with start.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-010 SHALL have port sum  output  WIDTH  registered result, held until next accepted start.
REQ-011 SHALL have port cout  output  1  registered final carry, held like sum.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 -> load a, b, cin into shift/carry registers; clear bit counter; clear sum and cout; go to SHIFT.
REQ-014 start SHALL be accepted only in IDLE; start in SHIFT or DONE SHALL be ignored, with no effect on the operation in progress.
REQ-015 SHIFT: each cycle, add LSB of A-shift, LSB of B-shift and carry register with one 1-bit full-adder cell.
REQ-016 SHIFT: each cycle, shift the sum bit into sum at the MSB end and shift sum right by one.
REQ-017 SHIFT: each cycle, shift both operand registers right by one, update the carry register, and increment the counter.
REQ-018 After the WIDTH-th SHIFT cycle (counter == WIDTH-1), SHALL load cout from the carry and go to DONE; bit 0 of the result ends in sum[0].
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 Latency SHALL be: done high WIDTH+1 cycles after the accepting edge; minimum start-to-start spacing WIDTH+2 cycles.
REQ-021 Result SHALL satisfy {cout,sum} = a + b + cin modulo 2^(WIDTH+1).
REQ-022 Counter SHALL be $clog2(WIDTH) bits; it SHALL never wrap inside an operation.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE and clear all internal registers.
REQ-024 rst_n=0 SHALL immediately clear outputs: busy=0, done=0, sum=0, cout=0, and ovf=0 when present.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-026 After reset release, the first rising edge with start=1 SHALL be accepted.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN defined: SHALL add output ovf (1 bit) with signed two's-complement overflow = carry into MSB XOR carry out of MSB.
REQ-028 With SERIAL_ADDER_OVF_EN, ovf SHALL be registered, updated at DONE entry, and held like cout.
REQ-029 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Package serial_adder_pkg SHALL hold the state enum typedef (IDLE, SHIFT, DONE) and constant DEFAULT_WIDTH=8.
REQ-031 The 1-bit add SHALL be one instance of the existing full_adder cell (inputs x, y, z; outputs s, c); no other sub-modules.

Verification (WIDTH=8)
REQ-032 a=0xFF, b=0x01, cin=0, start pulse -> done 9 cycles later; sum=0x00, cout=1.
REQ-033 a=0x5A, b=0x33, cin=1 -> sum=0x8E, cout=0; with OVF_EN, ovf=1.
REQ-034 start re-asserted during SHIFT with a=0x00, b=0x00 -> ignored; first result is still correct; busy stays high until done.
REQ-035 rst_n low at SHIFT cycle 4 -> busy=0, sum=0, no done pulse; new start after release -> correct result.
REQ-036 Back-to-back: start at the first IDLE cycle after done -> accepted; spacing 10 cycles; both results correct.
REQ-037 Random: 1000 random a/b/cin -> sum/cout match the reference model; done is exactly one cycle per accepted start.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell: s = x^y^z, c = majority(x,y,z).
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one bit per cycle through a single full_adder.
// Latency: WIDTH SHIFT cycles plus one DONE cycle; next start accepted WIDTH+2 cycles after the last.
// Backpressure: none; start is only honoured in IDLE and ignored while busy. Optional macro SERIAL_ADDER_OVF_EN adds ovf.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  assign last_bit = (cnt_q == LAST_BIT);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);

  full_adder u_fa (
    .x (a_q[0]),
    .y (b_q[0]),
    .z (carry_q),
    .s (fa_s),
    .c (fa_c)
  );

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept start only in IDLE, leave SHIFT after the last bit, DONE is a single cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load on accept, then shift one result bit in at the MSB end per SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_c;
          sum     <= {fa_s, sum[WIDTH-1:1]};
          if (last_bit) begin
            // Counter holds on the last bit so it never wraps mid-operation.
            cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB is the carry register; carry out is fa_c.
            ovf  <= carry_q ^ fa_c;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and random checks of serial_adder_ctrl at WIDTH=8.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int  n_vec;
  int  n_err;
  time accept_t;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called one delta after a rising edge; presents start immediately.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic [W-1:0] es, input logic ec,
                        input logic eo, input int inject_at);
    int  k;
    bit  seen;
    bit  busy_ok;
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk);
    accept_t = $time;
    #1;
    start = 1'b0;
    chk({tag, "_clr"}, {63'd0, busy}, 64'd1);
    seen = 1'b0;
    busy_ok = 1'b1;
    for (k = 1; k <= 20; k++) begin
      if (k == inject_at) begin
        start = 1'b1; a = '0; b = '0; cin = 1'b0;
      end
      if (k == inject_at + 2) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
      busy_ok = busy_ok & (busy === 1'b1);
    end
    start = 1'b0;
    // Start is presented the cycle before the accepting edge; done is visible W edges later.
    chk({tag, "_lat"}, 64'(k + 1), 64'(W + 1));
    chk({tag, "_seen"}, {63'd0, seen}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy_ok & (busy === 1'b1)}, 64'd1);
    chk({tag, "_sum"}, 64'(sum), 64'(es));
    chk({tag, "_cout"}, {63'd0, cout}, {63'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
`else
    if (eo === 1'bx) $display("note: unexpected unknown ovf expectation in %s", tag);
`endif
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
    logic         o;
  } vec_t;

  initial begin
    vec_t vt[6];
    time  t1;
    bit   any_done;
    logic [W-1:0] ra, rb, rs;
    logic         rc, rco, ro;
    logic [W:0]   ref9;

    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Hand-computed directed vectors: a, b, cin -> sum, cout, ovf
    vt[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[1] = '{8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1};
    vt[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[3] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
    vt[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++)
      run_op($sformatf("dir%0d", i), vt[i].a, vt[i].b, vt[i].c, vt[i].s, vt[i].co, vt[i].o, 0);

    // Result held while idle
    run_op("hold", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sum", 64'(sum), 64'h8E);
    chk("hold_cout", {63'd0, cout}, 64'd0);

    // Start re-asserted mid-SHIFT with zero operands is ignored
    run_op("ign", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, 1'b1, 3);

    // Reset during SHIFT aborts with no done pulse
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_sum", 64'(sum), 64'd0);
    chk("abort_cout", {63'd0, cout}, 64'd0);
    any_done = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      any_done = any_done | (done !== 1'b0);
    end
    chk("abort_nodone", {63'd0, any_done}, 64'd0);
    rst_n = 1'b1;
    run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0);

    // Back-to-back: second start in the first IDLE cycle after done
    run_op("b2b0", 8'hC3, 8'h4D, 1'b0, 8'h10, 1'b1, 1'b0, 0);
    t1 = accept_t;
    run_op("b2b1", 8'h01, 8'h7F, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    chk("b2b_space", 64'((accept_t - t1) / 10), 64'(W + 2));

    // Random operands against a reference model
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      ref9 = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      rs  = ref9[W-1:0];
      rco = ref9[W];
      ro  = (ra[W-1] == rb[W-1]) && (rs[W-1] != ra[W-1]);
      run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, rco, ro, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
